// File: rtl/periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// periph_bus_arbiter
//
// Purpose:
//   Shares one peripheral data bus between two bus masters: m0 (CPU) and
//   m1 (debug/DMA port). Requests are arbitrated round-robin and served one
//   at a time. Each transaction drives the bus for a fixed window
//   (GRANT + RD_LAT ISSUE cycles), samples read data on the last ISSUE cycle
//   and returns a one-cycle done pulse to the selected master.
//
// Ports:
//   clk, rst                 system clock (posedge), synchronous active-high reset
//   mX_req                   transaction request, held until mX_gnt
//   mX_addr/mX_w_r/mX_wdata  request fields, sampled when the request wins
//   mX_gnt                   1-cycle pulse: request accepted, fields latched
//   mX_done                  1-cycle pulse: transaction complete
//   mX_rdata                 read data, valid with mX_done and held afterwards
//   bus_addr/bus_w_r/        peripheral bus outputs (idle values when not
//   bus_wr_data              in GRANT/ISSUE)
//   bus_rd_data              read data, driven by the peripheral on negedge
//   bus_busy                 high in every state except IDLE
// ---------------------------------------------------------------------------
module periph_bus_arbiter #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                RD_LAT    = 1,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_w_r,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_w_r,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_w_r,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    output logic              bus_busy
);

    // Wide enough to hold RD_LAT itself.
    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic                sel_q,         sel_d;
    logic                last_q,        last_d;
    logic [CNT_W-1:0]    cnt_q,         cnt_d;
    logic [ADDR_W-1:0]   bus_addr_q,    bus_addr_d;
    logic                bus_w_r_q,     bus_w_r_d;
    logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
    logic                m0_gnt_q,      m0_gnt_d;
    logic                m1_gnt_q,      m1_gnt_d;
    logic                m0_done_q,     m0_done_d;
    logic                m1_done_q,     m1_done_d;
    logic [DATA_W-1:0]   m0_rdata_q,    m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q,    m1_rdata_d;
    logic                pick_m1;

    // Next-state and next-output logic for the transaction sequencer.
    // Every output is computed one cycle ahead so that it appears from a
    // flop in the same cycle as the state it belongs to: the gnt pulse and
    // the bus drive start together with GRANT, the done pulse and the bus
    // release happen together with DONE.
    // The selected request's fields are latched straight into the bus
    // output registers, which therefore double as the transaction latch
    // (bus_w_r_q still holds the read/write select on the last ISSUE cycle).
    // The round-robin pointer (last_q) only moves when a transaction
    // completes, so an aborted transaction does not change fairness.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        bus_addr_d    = bus_addr_q;
        bus_w_r_d     = bus_w_r_q;
        bus_wr_data_d = bus_wr_data_q;
        m0_gnt_d      = 1'b0;
        m1_gnt_d      = 1'b0;
        m0_done_d     = 1'b0;
        m1_done_d     = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        pick_m1       = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus_addr_d    = IDLE_ADDR;
                bus_w_r_d     = 1'b1;
                bus_wr_data_d = '0;
                if (m0_req || m1_req) begin
                    // Single requester wins outright; on a tie the master
                    // that was not served last goes first.
                    pick_m1 = (m0_req && m1_req) ? ~last_q : m1_req;
                    sel_d   = pick_m1;
                    if (pick_m1) begin
                        bus_addr_d    = m1_addr;
                        bus_w_r_d     = m1_w_r;
                        bus_wr_data_d = m1_wdata;
                        m1_gnt_d      = 1'b1;
                    end else begin
                        bus_addr_d    = m0_addr;
                        bus_w_r_d     = m0_w_r;
                        bus_wr_data_d = m0_wdata;
                        m0_gnt_d      = 1'b1;
                    end
                    state_d = S_GRANT;
                end
            end

            S_GRANT: begin
                cnt_d   = CNT_W'(RD_LAT);
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last ISSUE cycle: the peripheral has had the address
                    // for GRANT + RD_LAT cycles, so its read data is taken
                    // now. Writes leave the master's rdata untouched.
                    if (bus_w_r_q) begin
                        if (sel_q) begin
                            m1_rdata_d = bus_rd_data;
                        end else begin
                            m0_rdata_d = bus_rd_data;
                        end
                    end
                    bus_addr_d    = IDLE_ADDR;
                    bus_w_r_d     = 1'b1;
                    bus_wr_data_d = '0;
                    m0_done_d     = ~sel_q;
                    m1_done_d     = sel_q;
                    state_d       = S_DONE;
                end
            end

            S_DONE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any transaction in flight:
    // the bus returns to its idle values, no done pulse is produced and the
    // captured read data is cleared. The pointer resets to m1 so that m0
    // wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sel_q         <= 1'b0;
            last_q        <= 1'b1;
            cnt_q         <= '0;
            bus_addr_q    <= IDLE_ADDR;
            bus_w_r_q     <= 1'b1;
            bus_wr_data_q <= '0;
            m0_gnt_q      <= 1'b0;
            m1_gnt_q      <= 1'b0;
            m0_done_q     <= 1'b0;
            m1_done_q     <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            bus_addr_q    <= bus_addr_d;
            bus_w_r_q     <= bus_w_r_d;
            bus_wr_data_q <= bus_wr_data_d;
            m0_gnt_q      <= m0_gnt_d;
            m1_gnt_q      <= m1_gnt_d;
            m0_done_q     <= m0_done_d;
            m1_done_q     <= m1_done_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
        end
    end

    assign m0_gnt      = m0_gnt_q;
    assign m1_gnt      = m1_gnt_q;
    assign m0_done     = m0_done_q;
    assign m1_done     = m1_done_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign bus_addr    = bus_addr_q;
    assign bus_w_r     = bus_w_r_q;
    assign bus_wr_data = bus_wr_data_q;

    // Busy is a decode of the state register, so it is glitch-free and
    // aligned with the other registered outputs.
    assign bus_busy    = (state_q != S_IDLE);

endmodule
